regfile_seq_monitor: RTL
========================

Name: regfile_seq_monitor

Overview:
Synthesisable, parametrised successor to the bench-side "wait for register N == value" sequence checks. It snoops the core's register-file write port inside the user project and checks a programmable table of (register, expected value) entries, in-order or any-order. A programmable cycle timeout ends each run, and pass/fail status can be driven to checkbit GPIOs for silicon bring-up. It sits beside core0's datapath, fed from the regfile write port and configured over a simple write interface.

Parameters:
XLEN, 32, register data width
NREG, 32, number of architectural registers; AW = $clog2(NREG)
DEPTH, 8, maximum expected-entry count; IW = $clog2(DEPTH)
TO_W, 24, timeout counter width

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset
rf_we  in  1  regfile write strobe
rf_waddr  in  AW  regfile write address
rf_wdata  in  XLEN  regfile write data
cfg_we  in  1  table entry write
cfg_idx  in  IW  entry index
cfg_raddr  in  AW  expected register
cfg_value  in  XLEN  expected value
cfg_count  in  IW+1  active entries (0..DEPTH)
cfg_ordered  in  1  1=in-order, 0=any-order
cfg_timeout  in  TO_W  cycle limit; 0 = no timeout
start  in  1  begin run (pulse)
abort  in  1  return to IDLE (pulse)
busy  out  1  state==RUN
pass  out  1  state==PASS
fail  out  1  state==FAIL
timed_out  out  1  fail cause was timeout
matched  out  DEPTH  per-entry satisfied bitmap
match_cnt  out  IW+1  popcount of matched

Behaviour:
- Interface: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset: state IDLE. All outputs 0. Table entries, count latch, mode latch and timer cleared.
- FSM states are IDLE, RUN, PASS and FAIL.
  - start in IDLE, PASS or FAIL latches cfg_count, cfg_ordered and cfg_timeout, clears matched and the timer, and enters RUN.
  - start while in RUN is ignored.
  - abort from any state goes to IDLE and clears matched and timed_out. abort beats start in the same cycle.
- cfg_we is honoured only when state != RUN; entries with cfg_idx >= DEPTH are ignored.
- Writes with rf_waddr==0 are never matched (x0).
- Ordered mode: pointer ptr starts at 0. A write with rf_waddr==raddr[ptr] and rf_wdata==value[ptr] sets matched[ptr] and increments ptr. At most one advance per cycle. Non-matching writes are ignored; there is no fail on mismatch.
- Any-order mode: every unmatched entry with index < count whose (raddr, value) equals the write is set in the same cycle, so one write may satisfy several entries.
- Latency: a write sampled at edge n updates matched and match_cnt at n+1. If that write completes the table, PASS is also entered at n+1.
- Timer: increments every RUN cycle. When timer==cfg_timeout (nonzero) and the table is incomplete, enter FAIL with timed_out=1.
- Last match and timeout expiry in the same cycle: PASS wins.
- start with cfg_count==0 enters RUN, then PASS on the next cycle.
- The timer saturates at its maximum and does not wrap.
- PASS and FAIL hold until start or abort. matched holds its final value.
- wb_rst_i asserted mid-run aborts the run like reset, with no partial status retained.

Optional Feature:
MON_SHADOW_EN
- Defined: the block keeps a shadow copy of all NREG registers, updated on every rf_we. An entry is also satisfied when it becomes eligible (ordered: ptr reaches it; any-order: at start) and the shadow already holds the expected value. This gives level-sensitive "wait" semantics; shadow-based matches resolve one cycle after eligibility.
- Undefined: edge-only matching on write events; no shadow storage.

Decomposition:
- Package regfile_mon_pkg:
  - state enum (IDLE, RUN, PASS, FAIL)
  - entry typedef {raddr[AW], value[XLEN]}
  - X0_ADDR constant
- One natural sub-module, regfile_mon_entry_cmp: combinational per-entry compare (write match, plus shadow match under MON_SHADOW_EN), instantiated DEPTH times.

Test Plan:
- Ordered, 6 entries (3,3),(4,3),(5,6),(6,6),(7,3),(8,5), timeout 1000; drive the writes in that order -> matched=0x3F, match_cnt=6, pass=1 one cycle after the (8,5) write.
- Ordered, same table; write (4,3) before (3,3), then (3,3) only -> matched=0x01, no pass. After timeout 200: fail=1, timed_out=1.
- Any-order, entries (5,6),(6,6) plus duplicate (5,6); single write (5,6) -> matched=0x05. Then write (6,6) -> pass.
- Last match on the same cycle the timer reaches cfg_timeout=50 -> pass=1, fail=0. cfg_count=0 with start -> pass one cycle after RUN.
- Write (0,0) against entry (0,0) -> never matched. abort mid-run -> busy=0 and matched=0 next cycle. cfg_we during RUN -> table unchanged.
- MON_SHADOW_EN: write (7,3) before start with entry (7,3) -> matched[0] set without a new write. Without the macro -> stays 0.

Source files
------------

// File: rtl/regfile_seq_monitor_pkg.sv
// Shared types and constants for the register-file sequence monitor.
// Default widths here also size the table entry struct.
package regfile_mon_pkg;
    localparam int MON_XLEN  = 32;
    localparam int MON_NREG  = 32;
    localparam int MON_AW    = $clog2(MON_NREG);
    localparam int MON_DEPTH = 8;
    localparam int MON_TO_W  = 24;

    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_e;

    typedef struct packed {
        logic [MON_AW-1:0]   raddr;
        logic [MON_XLEN-1:0] value;
    } entry_t;

    localparam logic [MON_AW-1:0] X0_ADDR = '0;
endpackage

// File: rtl/regfile_seq_monitor_if.sv
// Snoop, configuration and status bundle for regfile_seq_monitor.
interface regfile_seq_monitor_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int DEPTH = 8,
    parameter int TO_W  = 24,
    localparam int AW   = $clog2(NREG),
    localparam int IW   = $clog2(DEPTH)
);
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            cfg_we;
    logic [IW-1:0]   cfg_idx;
    logic [AW-1:0]   cfg_raddr;
    logic [XLEN-1:0] cfg_value;
    logic [IW:0]     cfg_count;
    logic            cfg_ordered;
    logic [TO_W-1:0] cfg_timeout;
    logic            start;
    logic            abort;
    logic            busy;
    logic            pass;
    logic            fail;
    logic            timed_out;
    logic [DEPTH-1:0] matched;
    logic [IW:0]     match_cnt;

    modport master (
        output rf_we, rf_waddr, rf_wdata, cfg_we, cfg_idx, cfg_raddr, cfg_value,
               cfg_count, cfg_ordered, cfg_timeout, start, abort,
        input  busy, pass, fail, timed_out, matched, match_cnt
    );
    modport slave (
        input  rf_we, rf_waddr, rf_wdata, cfg_we, cfg_idx, cfg_raddr, cfg_value,
               cfg_count, cfg_ordered, cfg_timeout, start, abort,
        output busy, pass, fail, timed_out, matched, match_cnt
    );
endinterface

// File: rtl/regfile_seq_monitor_entry_cmp.sv
// Per-entry compare of the snooped write (and, with MON_SHADOW_EN, the shadow
// register value) against one expected (register, value) pair. x0 never matches.
module regfile_mon_entry_cmp
    import regfile_mon_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] value,
    input  logic            rf_we,
    input  logic [AW-1:0]   rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
`ifdef MON_SHADOW_EN
    input  logic [XLEN-1:0] sh_val,
`endif
    output logic            hit
);
    logic not_x0;
    logic wr_hit;

    assign not_x0 = (raddr != AW'(X0_ADDR));
    assign wr_hit = rf_we && (rf_waddr == raddr) && (rf_wdata == value);

`ifdef MON_SHADOW_EN
    assign hit = not_x0 && (wr_hit || (sh_val == value));
`else
    assign hit = not_x0 && wr_hit;
`endif
endmodule

// File: rtl/regfile_seq_monitor.sv
// Regfile write-port sequence monitor: checks a programmable (reg, value) table
// in-order or any-order with a cycle timeout. MON_SHADOW_EN adds level matching.
module regfile_seq_monitor
    import regfile_mon_pkg::*;
#(
    parameter int XLEN  = MON_XLEN,
    parameter int NREG  = MON_NREG,
    parameter int DEPTH = MON_DEPTH,
    parameter int TO_W  = MON_TO_W,
    localparam int AW   = $clog2(NREG),
    localparam int IW   = $clog2(DEPTH)
) (
    input logic            wb_clk_i,
    input logic            wb_rst_i,
    regfile_seq_monitor_if.slave bus
);
    state_e           state_q, state_d;
    entry_t           tbl [DEPTH];
    logic [IW:0]      cnt_q;
    logic             ord_q;
    logic [TO_W-1:0]  to_q, timer_q, timer_d;
    logic [IW:0]      ptr_q, ptr_d;
    logic [DEPTH-1:0] matched_q, matched_d, hit, active;
    logic             timed_out_q, timed_out_d;
    logic [IW:0]      match_cnt_q;
    logic             latch;

`ifdef MON_SHADOW_EN
    logic [XLEN-1:0] shadow [NREG];
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign active[i] = ((IW+1)'(i) < cnt_q);
        regfile_mon_entry_cmp #(.XLEN(XLEN), .AW(AW)) u_cmp (
            .raddr    (tbl[i].raddr),
            .value    (tbl[i].value),
            .rf_we    (bus.rf_we),
            .rf_waddr (bus.rf_waddr),
            .rf_wdata (bus.rf_wdata),
`ifdef MON_SHADOW_EN
            .sh_val   (shadow[tbl[i].raddr]),
`endif
            .hit      (hit[i])
        );
    end

    always_comb begin
        state_d     = state_q;
        matched_d   = matched_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q;
        timed_out_d = timed_out_q;
        latch       = 1'b0;
        if (bus.abort) begin
            state_d     = IDLE;
            matched_d   = '0;
            ptr_d       = '0;
            timer_d     = '0;
            timed_out_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    // Ordered mode advances at most one entry per cycle.
                    if (ord_q) begin
                        if (ptr_q < cnt_q && hit[ptr_q[IW-1:0]]) begin
                            matched_d[ptr_q[IW-1:0]] = 1'b1;
                            ptr_d = ptr_q + (IW+1)'(1);
                        end
                    end else begin
                        matched_d = matched_q | (hit & active);
                    end
                    timer_d = (timer_q == '1) ? timer_q : timer_q + TO_W'(1);
                    if ((matched_d & active) == active) begin
                        state_d = PASS;
                    end else if (to_q != '0 && timer_q == to_q) begin
                        state_d     = FAIL;
                        timed_out_d = 1'b1;
                    end
                end
                default: begin
                    if (bus.start) begin
                        state_d     = RUN;
                        matched_d   = '0;
                        ptr_d       = '0;
                        timer_d     = '0;
                        timed_out_d = 1'b0;
                        latch       = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ord_q       <= 1'b0;
            to_q        <= '0;
            timer_q     <= '0;
            ptr_q       <= '0;
            matched_q   <= '0;
            timed_out_q <= 1'b0;
            match_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ptr_q       <= ptr_d;
            matched_q   <= matched_d;
            timed_out_q <= timed_out_d;
            match_cnt_q <= (IW+1)'($countones(matched_d));
            if (latch) begin
                cnt_q <= bus.cfg_count;
                ord_q <= bus.cfg_ordered;
                to_q  <= bus.cfg_timeout;
            end
            if (bus.cfg_we && state_q != RUN && {1'b0, bus.cfg_idx} < (IW+1)'(DEPTH)) begin
                tbl[bus.cfg_idx].raddr <= bus.cfg_raddr;
                tbl[bus.cfg_idx].value <= bus.cfg_value;
            end
        end
    end

`ifdef MON_SHADOW_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int r = 0; r < NREG; r++) shadow[r] <= '0;
        end else if (bus.rf_we) begin
            shadow[bus.rf_waddr] <= bus.rf_wdata;
        end
    end
`endif

    assign bus.busy      = (state_q == RUN);
    assign bus.pass      = (state_q == PASS);
    assign bus.fail      = (state_q == FAIL);
    assign bus.timed_out = timed_out_q;
    assign bus.matched   = matched_q;
    assign bus.match_cnt = match_cnt_q;
endmodule
